// File: rtl/crossbar_readout_pkg.sv
// crossbar_pkg: shared types and constants for the crossbar readout block.
//   state_t : readout FSM states (IDLE, SEND, DONE)
//   NREG    : number of crossbar registers (fixed at 4)
//   IDX_W   : width of a register index
//   idx_t   : register index type (0 = R1 ... 3 = R4)
package crossbar_pkg;

  localparam int NREG  = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/crossbar_readout_prio_enc4.sv
// prio_enc4: combinational priority encoder, lowest-numbered set bit wins.
// Ports:
//   mask : 4-bit request mask, bit 0 = R1
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : high when at least one mask bit is set
module prio_enc4
  import crossbar_pkg::*;
(
  input  logic [3:0] mask,
  output idx_t       idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else if (mask[3]) idx = 2'd3;
  end

  assign any = |mask;

endmodule

// File: rtl/crossbar_readout.sv
// crossbar_readout: snapshots R1..R4 on Start and streams the registers
// selected by RoutExt onto DataOut with a valid/ready handshake, R1 first.
// Optional macro CROSSBAR_READOUT_TAG_EN adds the Tag output (register index
// of the word on DataOut, 0 when Valid is low).
// Ports:
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   Start, RoutExt    : readout request and register select mask ([1] = R1)
//   R1..R4            : crossbar register contents
//   DataOut, Valid    : output word and its valid flag
//   Ready             : consumer accept
//   Busy, Done        : high in SEND/DONE; one-cycle end-of-readout pulse
//   Tag (optional)    : register index of DataOut
module crossbar_readout
  import crossbar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:4]       RoutExt,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  input  logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] DataOut,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Done
`ifdef CROSSBAR_READOUT_TAG_EN
  ,
  output logic [IDX_W-1:0] Tag
`endif
);

  state_t           state;
  logic [WIDTH-1:0] snap [NREG];
  logic [3:0]       pend;

  // Internal masks are numbered from 0 so bit 0 is R1.
  logic [3:0]       ext_mask;
  logic [3:0]       pend_clr;
  idx_t             start_idx, cur_idx, nxt_idx;
  logic             start_any, cur_any, nxt_any;
  logic [WIDTH-1:0] start_word;

  assign ext_mask = {RoutExt[4], RoutExt[3], RoutExt[2], RoutExt[1]};
  assign pend_clr = pend & ~(4'b0001 << cur_idx);

  // First word is loaded straight from the inputs at the capture edge so the
  // registered DataOut is ready on the cycle after Start.
  prio_enc4 u_enc_start (.mask(ext_mask), .idx(start_idx), .any(start_any));
  prio_enc4 u_enc_cur   (.mask(pend),     .idx(cur_idx),   .any(cur_any));
  prio_enc4 u_enc_nxt   (.mask(pend_clr), .idx(nxt_idx),   .any(nxt_any));

  always_comb begin
    start_word = R1;
    case (start_idx)
      2'd0:    start_word = R1;
      2'd1:    start_word = R2;
      2'd2:    start_word = R3;
      default: start_word = R4;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pend    <= '0;
      for (int i = 0; i < NREG; i++) snap[i] <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DataOut <= '0;
`ifdef CROSSBAR_READOUT_TAG_EN
      Tag     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Busy <= 1'b1;
            if (start_any) begin
              state   <= SEND;
              snap[0] <= R1;
              snap[1] <= R2;
              snap[2] <= R3;
              snap[3] <= R4;
              pend    <= ext_mask;
              Valid   <= 1'b1;
              DataOut <= start_word;
`ifdef CROSSBAR_READOUT_TAG_EN
              Tag     <= start_idx;
`endif
            end else begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (Ready && cur_any) begin
            pend <= pend_clr;
            if (nxt_any) begin
              DataOut <= snap[nxt_idx];
`ifdef CROSSBAR_READOUT_TAG_EN
              Tag     <= nxt_idx;
`endif
            end else begin
              state   <= DONE;
              Valid   <= 1'b0;
              DataOut <= '0;
              Done    <= 1'b1;
`ifdef CROSSBAR_READOUT_TAG_EN
              Tag     <= '0;
`endif
            end
          end
        end

        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          Valid   <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          DataOut <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_readout.sv
// Bench for crossbar_readout: a queue-based readout model plus directed
// vectors with literal expectations. Define CROSSBAR_READOUT_TAG_EN to also
// exercise the Tag output.
module tb_crossbar_readout;

  logic       Clock = 1'b0;
  logic       Reset, Start, Ready;
  logic [1:4] RoutExt;
  logic [7:0] R1, R2, R3, R4, DataOut;
  logic       Valid, Busy, Done;
`ifdef CROSSBAR_READOUT_TAG_EN
  logic [1:0] Tag;
`endif

  crossbar_readout #(.WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .RoutExt(RoutExt),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4),
    .DataOut(DataOut), .Valid(Valid), .Ready(Ready),
    .Busy(Busy), .Done(Done)
`ifdef CROSSBAR_READOUT_TAG_EN
    , .Tag(Tag)
`endif
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a readout is a queue of (word, index) pairs captured at Start;
  // each accepted beat pops one, an empty queue ends in a one-cycle Done.
  typedef struct { logic [7:0] w; int t; } item_t;
  item_t mq[$];
  int    phase = 0;     // 0 idle, 1 sending, 2 done pulse
  bit    check_en = 0;

  initial forever begin
    @(posedge Clock);
    if (Reset === 1'b1) begin
      mq.delete();
      phase    = 0;
      check_en = 1;
    end else begin
      case (phase)
        0: if (Start) begin
          logic [7:0] rv [4];
          rv[0] = R1; rv[1] = R2; rv[2] = R3; rv[3] = R4;
          for (int i = 1; i <= 4; i++)
            if (RoutExt[i]) mq.push_back('{w: rv[i-1], t: i-1});
          phase = (mq.size() != 0) ? 1 : 2;
        end
        1: if (Ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge Clock);
    if (check_en) begin
      logic       ev;
      logic [7:0] ew;
      ev = (phase == 1);
      ew = ev ? mq[0].w : 8'h00;
      chk("m_valid", Valid, ev);
      chk("m_data", DataOut, ew);
      chk("m_busy", Busy, phase != 0);
      chk("m_done", Done, phase == 2);
`ifdef CROSSBAR_READOUT_TAG_EN
      chk("m_tag", Tag, ev ? mq[0].t[1:0] : 2'd0);
`endif
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic pulse_start(input logic [1:4] m);
    RoutExt = m;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Ready = 1'b1; RoutExt = 4'b0000;
    R1 = 8'h11; R2 = 8'h22; R3 = 8'h33; R4 = 8'h44;
    repeat (2) tick();
    chk("rst_valid", Valid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_data", DataOut, 8'h00);
    Reset = 1'b0;
    tick();

    // 1: full readout, Ready held high
    pulse_start(4'b1111);
    chk("t1_w1", {Valid, DataOut}, {1'b1, 8'h11});
    tick(); chk("t1_w2", {Valid, DataOut}, {1'b1, 8'h22});
    tick(); chk("t1_w3", {Valid, DataOut}, {1'b1, 8'h33});
    tick(); chk("t1_w4", {Valid, DataOut}, {1'b1, 8'h44});
    tick(); chk("t1_done", {Done, Busy, Valid}, 3'b110);
    tick(); chk("t1_idle", {Done, Busy}, 2'b00);
    tick();

    // 2: sparse mask R2, R4
    pulse_start(4'b0101);
    chk("t2_w1", {Valid, DataOut}, {1'b1, 8'h22});
`ifdef CROSSBAR_READOUT_TAG_EN
    chk("t2_tag1", Tag, 2'd1);
`endif
    tick(); chk("t2_w2", {Valid, DataOut}, {1'b1, 8'h44});
`ifdef CROSSBAR_READOUT_TAG_EN
    chk("t2_tag2", Tag, 2'd3);
`endif
    tick(); chk("t2_done", {Done, Valid}, 2'b10);
    tick();

    // 3: backpressure on word 1 while R1 and RoutExt change
    Ready = 1'b0;
    pulse_start(4'b1111);
    R1 = 8'hFF; RoutExt = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold", {Valid, DataOut}, {1'b1, 8'h11});
      if (i < 2) tick();
    end
    Ready = 1'b1;
    tick(); chk("t3_w2", {Valid, DataOut}, {1'b1, 8'h22});
    tick(); chk("t3_w3", DataOut, 8'h33);
    tick(); chk("t3_w4", DataOut, 8'h44);
    tick(); chk("t3_done", Done, 1'b1);
    R1 = 8'h11;
    tick();

    // 4: empty request
    pulse_start(4'b0000);
    chk("t4_done", {Done, Busy, Valid}, 3'b110);
    tick(); chk("t4_idle", {Done, Busy, Valid}, 3'b000);

    // 5: reset during word 2, then replay
    pulse_start(4'b1111);
    tick(); chk("t5_w2", DataOut, 8'h22);
    Reset = 1'b1;
    tick(); chk("t5_rst", {Valid, Busy, DataOut}, 10'h000);
    Reset = 1'b0;
    tick();
    pulse_start(4'b1111);
    chk("t5_replay", {Valid, DataOut}, {1'b1, 8'h11});
    repeat (5) tick();

    // 6: Start during SEND with a different mask is ignored
    pulse_start(4'b1111);
    tick();
    pulse_start(4'b0011);
    RoutExt = 4'b1111;
    chk("t6_w3", DataOut, 8'h33);
    tick(); chk("t6_w4", DataOut, 8'h44);
    tick(); chk("t6_done", Done, 1'b1);
    tick(); chk("t6_single", {Done, Busy}, 2'b00);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crossbar_readout.md
Name: crossbar_readout

Overview:
Read-side companion to the 4-register crossbar. On a start request it snapshots R1..R4 and streams the registers selected by a mask onto an external WIDTH-bit bus with a valid/ready handshake, one word per accepted beat, in register order R1→R4. It sits between the crossbar register outputs and the external data consumer. Its enable mask RoutExt mirrors the crossbar's RinExt load-enable mask.

Parameters:
WIDTH, 8, data width of each register and of DataOut
NREG, 4, number of registers; fixed at 4 and not overridable in this revision

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous reset, active-high
Start  input  1  request a readout; sampled only in IDLE
RoutExt  input  [1:4]  select mask; bit i selects register Ri
R1  input  WIDTH  crossbar register 1 contents
R2  input  WIDTH  crossbar register 2 contents
R3  input  WIDTH  crossbar register 3 contents
R4  input  WIDTH  crossbar register 4 contents
DataOut  output  WIDTH  current word; all zero when Valid=0
Valid  output  1  DataOut holds a word
Ready  input  1  consumer accepts the word (transfer = Valid & Ready)
Busy  output  1  high in SEND and DONE
Done  output  1  one-cycle pulse at end of a readout

Behaviour:
- Reset, taken at any cycle including mid-readout:
  - state=IDLE; snapshot and mask registers cleared.
  - Outputs: Valid=0, Busy=0, Done=0, DataOut=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - Start=1 with RoutExt≠0: at that edge, capture R1..R4 into the snapshot and RoutExt into the pending mask; go to SEND.
  - Start=1 with RoutExt=0: go to DONE, with no snapshot and no Valid.
  - Start=0: stay in IDLE.
- SEND:
  - Index = lowest-numbered set bit of the pending mask (R1 has highest priority).
  - Valid=1; DataOut = snapshot[index].
  - On a transfer: clear that bit. If the mask becomes zero, go to DONE; otherwise stay and present the next word the following cycle.
  - Ready held high: one word per cycle, no bubbles.
- DONE: Done=1 and Busy=1 for exactly one cycle, Valid=0; then return to IDLE.
- Latency:
  - Start sampled at edge t → first Valid at cycle t+1.
  - Done asserts the cycle after the last transfer.
  - Minimum IDLE-to-IDLE time is N+2 cycles for N selected registers.
- Handshake rules:
  - Once Valid=1, Valid and DataOut stay stable until the transfer. No retraction.
  - Ready is ignored while Valid=0.
- Snapshot isolation: changes on R1..R4 or RoutExt after capture do not affect the readout in progress.
- Start is ignored in SEND and DONE; no queuing.
- Start in the cycle right after Done (state is back in IDLE) is accepted normally.
- Outputs are decoded from registered state. There is no combinational path from Start, RoutExt or Ri to any output.

Optional Feature:
Macro: CROSSBAR_READOUT_TAG_EN
- Defined:
  - Extra output port Tag, 2 bits, equal to the register index of DataOut (0=R1 … 3=R4).
  - Tag is valid and stable under the same rules as DataOut; it is 0 when Valid=0.
- Undefined:
  - The Tag port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package crossbar_pkg holds:
  - state enum (IDLE, SEND, DONE)
  - constant NREG=4
  - constant IDX_W=2
  - typedef for the register index
- One sub-module, prio_enc4:
  - 4-bit mask in, IDX_W index of the lowest-numbered set bit out, plus an any-set flag.
  - Purely combinational.

Test Plan:
1. Full readout: R1..R4 = 0x11/0x22/0x33/0x44, RoutExt=1111, Ready=1, Start pulse at edge t → Valid high on cycles t+1..t+4 with DataOut 0x11, 0x22, 0x33, 0x44; Done=1 at t+5; Busy low at t+6.
2. Sparse mask: RoutExt[2]=RoutExt[4]=1, others 0 → exactly two words, 0x22 then 0x44. With the tag macro defined, Tag = 1 then 3.
3. Backpressure and isolation: Ready=0 for 3 cycles during word 1, while R1 is changed to 0xFF → DataOut holds 0x11 and Valid holds 1. Release Ready → sequence resumes unchanged.
4. Empty request: RoutExt=0000 with Start → Done pulse at t+1; Valid never asserts.
5. Mid-readout reset: Reset asserted during word 2 → next cycle Valid=0, Busy=0, DataOut=0. A fresh Start then replays from R1.
6. Start while busy: Start pulsed during SEND with a different mask → ignored; the original sequence completes with a single Done.
